// File: rtl/mm_fpu_rr_arbiter.sv
// Round-robin front end that shares one fully pipelined FP ALU between N_REQ requesters.
// A tag pipe tracks which requester owns each in-flight op so its result can be steered back.
module mm_fpu_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int LATENCY = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_hold,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  input  logic [N_REQ*OP_W-1:0]   i_req_op,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_alu_valid,
  output logic [DATA_W-1:0]       o_alu_a,
  output logic [DATA_W-1:0]       o_alu_b,
  output logic [OP_W-1:0]         o_alu_op,
  input  logic [DATA_W-1:0]       i_alu_result,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic                    o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              alu_valid_q, alu_valid_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [IDX_W-1:0]  alu_idx_q, alu_idx_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]  tag_idx_q [LATENCY];
  logic [IDX_W-1:0]  tag_idx_d [LATENCY];
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    scan_pos;
  logic              hs;

  // Handshake: requester i transfers a/b/op on a rising edge where
  // i_req_valid[i] & o_req_ready[i]. Ready is one-hot or zero, never depends on
  // responses, and is forced low while holding or in reset. Responses have no
  // back-pressure: o_rsp_valid must be accepted the cycle it is shown.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_pos >= (IDX_W+1)'(N_REQ)) begin
        scan_pos = scan_pos - (IDX_W+1)'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_found && (scan_pos == (IDX_W+1)'(j)) && i_req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
    end
  end

  assign hs = win_found & ~i_hold & ~i_reset;

  always_comb begin
    o_req_ready = '0;
    for (int j = 0; j < N_REQ; j++) begin
      o_req_ready[j] = hs && (win_idx == IDX_W'(j));
    end
  end

  // Issue register: operands are captured only on a handshake and otherwise held.
  always_comb begin
    alu_valid_d = hs;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_idx_d   = alu_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (hs) begin
      alu_idx_d = win_idx;
      rr_ptr_d  = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + IDX_W'(1);
      for (int j = 0; j < N_REQ; j++) begin
        if (win_idx == IDX_W'(j)) begin
          alu_a_d  = i_req_a[j*DATA_W +: DATA_W];
          alu_b_d  = i_req_b[j*DATA_W +: DATA_W];
          alu_op_d = i_req_op[j*OP_W +: OP_W];
        end
      end
    end
  end

  // Tag pipe: the last stage is valid in the same cycle as the matching ALU result.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = alu_valid_q;
    tag_idx_d[0] = alu_idx_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[LATENCY-1]) begin
      rsp_data_d = i_alu_result;
      for (int j = 0; j < N_REQ; j++) begin
        rsp_valid_d[j] = (tag_idx_q[LATENCY-1] == IDX_W'(j));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr_q    <= '0;
      alu_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_idx_q   <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_idx_q[i] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      alu_valid_q <= alu_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_idx_q   <= alu_idx_d;
      tag_vld_q   <= tag_vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_idx_q[i] <= tag_idx_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_alu_valid = alu_valid_q;
  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = alu_valid_q | (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_mm_fpu_rr_arbiter.sv
// Directed bench for mm_fpu_rr_arbiter: a behavioural ALU pipe feeds results back,
// and every response is matched against an expected queue of {cycle, one-hot, data}.
module tb_mm_fpu_rr_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 3;
  localparam int LATENCY = 4;
  localparam int EXP_W   = 32 + N_REQ + DATA_W;

  logic                    i_clk = 1'b0;
  logic                    i_reset;
  logic                    i_hold;
  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ*DATA_W-1:0] i_req_a;
  logic [N_REQ*DATA_W-1:0] i_req_b;
  logic [N_REQ*OP_W-1:0]   i_req_op;
  logic [N_REQ-1:0]        o_req_ready;
  logic                    o_alu_valid;
  logic [DATA_W-1:0]       o_alu_a;
  logic [DATA_W-1:0]       o_alu_b;
  logic [OP_W-1:0]         o_alu_op;
  logic [DATA_W-1:0]       i_alu_result;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [DATA_W-1:0]       o_rsp_data;
  logic                    o_busy;

  int total   = 0;
  int bad     = 0;
  int cyc_cnt = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [EXP_W-1:0]  mon_exp;
  logic [DATA_W-1:0] alu_sr [LATENCY];

  mm_fpu_rr_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .LATENCY(LATENCY)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_hold(i_hold),
    .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
    .o_req_ready(o_req_ready), .o_alu_valid(o_alu_valid), .o_alu_a(o_alu_a),
    .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_result(i_alu_result),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_busy(o_busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  // ADD of 1.0 + 2.0 returns 3.0; every other op uses an integer mix so results are distinct.
  function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [OP_W-1:0] op);
    if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a + b) ^ {29'd0, op} ^ 32'h5A5A_0000;
  endfunction

  // Behavioural ALU: result visible LATENCY cycles after o_alu_valid; junk otherwise.
  always @(posedge i_clk) begin
    alu_sr[0] <= o_alu_valid ? alu_fn(o_alu_a, o_alu_b, o_alu_op) : 32'hDEAD_BEEF;
    for (int i = 1; i < LATENCY; i++) alu_sr[i] <= alu_sr[i-1];
  end
  assign i_alu_result = alu_sr[LATENCY-1];

  // ---------------- scoreboard ----------------
  always @(negedge i_clk) begin
    if (|o_rsp_valid) begin
      total++;
      assert (exp_q.size() > 0)
      else begin
        bad++;
        $error("FAIL rsp_spurious obs=%0h exp=none cyc=%0d", o_rsp_valid, cyc_cnt);
      end
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        total++;
        assert ({32'(cyc_cnt), o_rsp_valid, o_rsp_data} === mon_exp)
        else begin
          bad++;
          $error("FAIL rsp_match obs=%0h exp=%0h", {32'(cyc_cnt), o_rsp_valid, o_rsp_data}, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  task automatic set_ops(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [OP_W-1:0] op);
    i_req_a[i*DATA_W +: DATA_W] = a;
    i_req_b[i*DATA_W +: DATA_W] = b;
    i_req_op[i*OP_W +: OP_W]    = op;
  endtask

  task automatic load_ops(input int i, input int k);
    set_ops(i, 32'h1000_0000 + 32'(k*16 + i), 32'h0200_0000 + 32'(k), 3'(k % 8));
  endtask

  // Called before the handshake edge: the response is due LATENCY+1 edges after it.
  task automatic push_exp(input int i);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    exp_q.push_back({32'(cyc_cnt + LATENCY + 2), oh,
                     alu_fn(i_req_a[i*DATA_W +: DATA_W], i_req_b[i*DATA_W +: DATA_W],
                            i_req_op[i*OP_W +: OP_W])});
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [N_REQ-1:0] oh;
    i_reset     = 1'b1;
    i_hold      = 1'b0;
    i_req_valid = '1;
    i_req_a     = '0;
    i_req_b     = '0;
    i_req_op    = '0;
    for (int i = 0; i < N_REQ; i++) load_ops(i, 0);

    // 1: reset with every requester valid
    tick();
    tick();
    mid();
    chk("rst_ready", EXP_W'(o_req_ready), EXP_W'(0));
    chk("rst_alu_valid", EXP_W'(o_alu_valid), EXP_W'(0));
    chk("rst_rsp_valid", EXP_W'(o_rsp_valid), EXP_W'(0));
    chk("rst_busy", EXP_W'(o_busy), EXP_W'(0));
    chk("rst_alu_a", EXP_W'(o_alu_a), EXP_W'(0));

    // 2: single ADD from requester 2
    tick();
    i_reset     = 1'b0;
    i_req_valid = 4'b0100;
    set_ops(2, 32'h3F80_0000, 32'h4000_0000, 3'd0);
    mid();
    chk("t2_grant", EXP_W'(o_req_ready), EXP_W'(4'b0100));
    push_exp(2);
    tick();
    i_req_valid = '0;
    mid();
    chk("t2_alu_valid", EXP_W'(o_alu_valid), EXP_W'(1));
    chk("t2_alu_a", EXP_W'(o_alu_a), EXP_W'(32'h3F80_0000));
    chk("t2_alu_b", EXP_W'(o_alu_b), EXP_W'(32'h4000_0000));
    chk("t2_alu_op", EXP_W'(o_alu_op), EXP_W'(0));
    for (int k = 1; k <= LATENCY; k++) begin
      tick();
      mid();
      chk("t2_rsp_early", EXP_W'(o_rsp_valid), EXP_W'(0));
    end
    tick();
    mid();
    chk("t2_rsp_valid", EXP_W'(o_rsp_valid), EXP_W'(4'b0100));
    chk("t2_rsp_data", EXP_W'(o_rsp_data), EXP_W'(32'h4040_0000));
    tick();
    mid();
    chk("t2_rsp_once", EXP_W'(o_rsp_valid), EXP_W'(0));
    chk("t2_busy_lo", EXP_W'(o_busy), EXP_W'(0));

    // 3: all four valid for 12 cycles from rr_ptr=0
    tick();
    do_reset();
    for (int i = 0; i < N_REQ; i++) load_ops(i, 0);
    i_req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      mid();
      oh = N_REQ'(1) << (k % N_REQ);
      chk("t3_grant", EXP_W'(o_req_ready), EXP_W'(oh));
      push_exp(k % N_REQ);
      tick();
      load_ops(k % N_REQ, k + 1);
    end
    i_req_valid = '0;
    repeat (LATENCY + 2) tick();
    mid();
    chk("t3_drained", EXP_W'(exp_q.size()), EXP_W'(0));
    chk("t3_busy_lo", EXP_W'(o_busy), EXP_W'(0));

    // 4: requesters 1 and 3 with rr_ptr=2, then wrap 3->0
    tick();
    i_req_valid = 4'b0010;
    load_ops(1, 20);
    mid();
    chk("t4_solo", EXP_W'(o_req_ready), EXP_W'(4'b0010));
    push_exp(1);
    tick();
    load_ops(1, 21);
    load_ops(3, 22);
    i_req_valid = 4'b1010;
    mid();
    chk("t4_first", EXP_W'(o_req_ready), EXP_W'(4'b1000));
    push_exp(3);
    tick();
    load_ops(3, 23);
    mid();
    chk("t4_wrap", EXP_W'(o_req_ready), EXP_W'(4'b0010));
    push_exp(1);
    tick();
    load_ops(1, 24);
    mid();
    chk("t4_again", EXP_W'(o_req_ready), EXP_W'(4'b1000));
    push_exp(3);
    tick();
    i_req_valid = '0;
    repeat (LATENCY + 2) tick();

    // 5: hold with three ops in flight
    i_req_valid = '1;
    for (int i = 0; i < N_REQ; i++) load_ops(i, 30);
    for (int k = 0; k < 3; k++) begin
      mid();
      oh = N_REQ'(1) << k;
      chk("t5_grant", EXP_W'(o_req_ready), EXP_W'(oh));
      push_exp(k);
      tick();
      load_ops(k, 31 + k);
    end
    i_hold = 1'b1;
    mid();
    chk("t5_hold_now", EXP_W'(o_req_ready), EXP_W'(0));
    for (int k = 1; k <= LATENCY + 1; k++) begin
      tick();
      mid();
      chk("t5_hold_ready", EXP_W'(o_req_ready), EXP_W'(0));
    end
    chk("t5_busy_hi", EXP_W'(o_busy), EXP_W'(1));
    tick();
    mid();
    chk("t5_busy_lo", EXP_W'(o_busy), EXP_W'(0));
    chk("t5_drained", EXP_W'(exp_q.size()), EXP_W'(0));
    i_hold      = 1'b0;
    i_req_valid = '0;

    // 6: reset two cycles after an issue discards it and clears rr_ptr
    tick();
    i_req_valid = 4'b0010;
    load_ops(1, 40);
    mid();
    chk("t6_grant", EXP_W'(o_req_ready), EXP_W'(4'b0010));
    tick();
    i_req_valid = '0;
    tick();
    i_reset = 1'b1;
    mid();
    chk("t6_rst_ready", EXP_W'(o_req_ready), EXP_W'(0));
    tick();
    i_reset = 1'b0;
    mid();
    chk("t6_rst_busy", EXP_W'(o_busy), EXP_W'(0));
    chk("t6_rst_rsp", EXP_W'(o_rsp_valid), EXP_W'(0));
    tick();
    i_req_valid = 4'b1010;
    load_ops(1, 41);
    load_ops(3, 42);
    mid();
    chk("t6_lowest", EXP_W'(o_req_ready), EXP_W'(4'b0010));
    push_exp(1);
    tick();
    i_req_valid = '0;
    repeat (LATENCY + 4) tick();
    mid();
    chk("t6_drained", EXP_W'(exp_q.size()), EXP_W'(0));
    chk("t6_busy_lo", EXP_W'(o_busy), EXP_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
